// File: rtl/comb_sequencer_if.sv
// Control bundle between the combination sequencer and its datapath peers
// (COO loader, FM_WM/MAC datapath, result memory and argmax unit).
interface comb_sequencer_if #(
  parameter int unsigned FEATURE_ROWS    = 6,
  parameter int unsigned NUM_OF_NODES    = 6,
  parameter int unsigned COO_NUM_OF_COLS = 6
);
  localparam int unsigned ROW_W  = (FEATURE_ROWS > 1)    ? $clog2(FEATURE_ROWS)    : 1;
  localparam int unsigned NODE_W = (NUM_OF_NODES > 1)    ? $clog2(NUM_OF_NODES)    : 1;
  localparam int unsigned COO_BW = (COO_NUM_OF_COLS > 1) ? $clog2(COO_NUM_OF_COLS) : 1;

  logic              start;
  logic              argmax_done;
  logic [COO_BW-1:0] coo_addr;
  logic              coo_rd_en;
  logic [NODE_W-1:0] fm_wm_rd_row;
  logic              mac_clear;
  logic              mac_en;
  logic              wr_en;
  logic [ROW_W-1:0]  wr_row;
  logic              argmax_start;
  logic              busy;
  logic              done;

  // Sequencer side: takes requests, drives every strobe and index.
  modport master (
    input  start, argmax_done,
    output coo_addr, coo_rd_en, fm_wm_rd_row, mac_clear, mac_en,
           wr_en, wr_row, argmax_start, busy, done
  );

  // Environment side: issues start, returns argmax completion.
  modport slave (
    output start, argmax_done,
    input  coo_addr, coo_rd_en, fm_wm_rd_row, mac_clear, mac_en,
           wr_en, wr_row, argmax_start, busy, done
  );
endinterface

// File: rtl/comb_sequencer.sv
// Combination-pass sequencer: loads COO edges, runs one MAC inner product per
// feature row, writes each row, then launches argmax and waits for it.
module comb_sequencer #(
  parameter int unsigned FEATURE_ROWS    = 6,
  parameter int unsigned NUM_OF_NODES    = 6,
  parameter int unsigned COO_NUM_OF_COLS = 6
) (
  input  logic             clk,
  input  logic             reset,
  comb_sequencer_if.master bus
);
  localparam int unsigned ROW_W  = (FEATURE_ROWS > 1)    ? $clog2(FEATURE_ROWS)    : 1;
  localparam int unsigned NODE_W = (NUM_OF_NODES > 1)    ? $clog2(NUM_OF_NODES)    : 1;
  localparam int unsigned COO_BW = (COO_NUM_OF_COLS > 1) ? $clog2(COO_NUM_OF_COLS) : 1;

  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(FEATURE_ROWS - 1);
  localparam logic [NODE_W-1:0] NODE_LAST = NODE_W'(NUM_OF_NODES - 1);
  localparam logic [COO_BW-1:0] COO_LAST  = COO_BW'(COO_NUM_OF_COLS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    COMPUTE = 3'd2,
    WRITE   = 3'd3,
    ARGMAX  = 3'd4,
    DONE    = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [COO_BW-1:0] coo_addr_q, coo_addr_d;
  logic [NODE_W-1:0] node_q, node_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              coo_rd_en_q, coo_rd_en_d;
  logic              mac_clear_q, mac_clear_d;
  logic              mac_en_q, mac_en_d;
  logic              wr_en_q, wr_en_d;
  logic              argmax_start_q, argmax_start_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Next state, counters, and the strobes decoded from the upcoming state.
  always_comb begin
    state_d    = state_q;
    coo_addr_d = coo_addr_q;
    node_d     = node_q;
    row_d      = row_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = LOAD;
          coo_addr_d = '0;
        end
      end
      LOAD: begin
        if (coo_addr_q == COO_LAST) begin
          state_d = COMPUTE;
          node_d  = '0;
          row_d   = '0;
        end else begin
          coo_addr_d = coo_addr_q + COO_BW'(1);
        end
      end
      COMPUTE: begin
        if (node_q == NODE_LAST) state_d = WRITE;
        else                     node_d  = node_q + NODE_W'(1);
      end
      WRITE: begin
        if (row_q == ROW_LAST) begin
          state_d = ARGMAX;
        end else begin
          state_d = COMPUTE;
          row_d   = row_q + ROW_W'(1);
          node_d  = '0;
        end
      end
      ARGMAX: begin
        // The entry cycle is marked by argmax_start; a done seen then is stale.
        if (!argmax_start_q && bus.argmax_done) state_d = DONE;
      end
      DONE: begin
        state_d    = IDLE;
        coo_addr_d = '0;
        node_d     = '0;
        row_d      = '0;
      end
      default: begin
        state_d    = IDLE;
        coo_addr_d = '0;
        node_d     = '0;
        row_d      = '0;
      end
    endcase

    coo_rd_en_d    = (state_d == LOAD);
    mac_en_d       = (state_d == COMPUTE);
    mac_clear_d    = (state_d == COMPUTE) && (node_d == '0);
    wr_en_d        = (state_d == WRITE);
    argmax_start_d = (state_d == ARGMAX) && (state_q != ARGMAX);
    busy_d         = (state_d != IDLE);
    done_d         = (state_d == DONE);
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      coo_addr_q     <= '0;
      node_q         <= '0;
      row_q          <= '0;
      coo_rd_en_q    <= 1'b0;
      mac_clear_q    <= 1'b0;
      mac_en_q       <= 1'b0;
      wr_en_q        <= 1'b0;
      argmax_start_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      coo_addr_q     <= coo_addr_d;
      node_q         <= node_d;
      row_q          <= row_d;
      coo_rd_en_q    <= coo_rd_en_d;
      mac_clear_q    <= mac_clear_d;
      mac_en_q       <= mac_en_d;
      wr_en_q        <= wr_en_d;
      argmax_start_q <= argmax_start_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign bus.coo_addr     = coo_addr_q;
  assign bus.coo_rd_en    = coo_rd_en_q;
  assign bus.fm_wm_rd_row = node_q;
  assign bus.mac_clear    = mac_clear_q;
  assign bus.mac_en       = mac_en_q;
  assign bus.wr_en        = wr_en_q;
  assign bus.wr_row       = row_q;
  assign bus.argmax_start = argmax_start_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
endmodule

// File: tb/tb_comb_sequencer.sv
// Scoreboard bench for comb_sequencer: stimulus pushes the expected strobe
// events of each pass, a negedge monitor pops and compares them.
module tb_comb_sequencer;
  localparam int R = 6;
  localparam int N = 6;
  localparam int C = 6;
  localparam int INF = 32'h7fff_ffff;

  // kind: 0 coo read, 1 mac, 2 write, 3 argmax launch, 4 done, 5 stray clear
  typedef struct {
    int cyc;
    int kind;
    int idx;
    int idx2;
    bit clr;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   busy_lo = 1;
  int   busy_hi = 0;
  ev_t  exp_q[$];

  comb_sequencer_if #(.FEATURE_ROWS(R), .NUM_OF_NODES(N), .COO_NUM_OF_COLS(C)) bus_if ();

  comb_sequencer #(.FEATURE_ROWS(R), .NUM_OF_NODES(N), .COO_NUM_OF_COLS(C)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  function automatic void push_ev(int c, int k, int i, int i2, bit cl);
    ev_t e;
    e.cyc = c; e.kind = k; e.idx = i; e.idx2 = i2; e.clr = cl;
    exp_q.push_back(e);
  endfunction

  // Expected strobe timeline of one pass, cycle 1 being the first after the start edge.
  function automatic void push_pass(int base);
    for (int a = 0; a < C; a++) push_ev(base + 1 + a, 0, a, 0, 1'b0);
    for (int r = 0; r < R; r++) begin
      int row_base = base + C + 1 + r * (N + 1);
      for (int n = 0; n < N; n++) push_ev(row_base + n, 1, n, r, n == 0);
      push_ev(row_base + N, 2, 0, r, 1'b0);
    end
    push_ev(base + C + 1 + R * (N + 1), 3, 0, R - 1, 1'b0);
  endfunction

  function automatic void flush_after(int lim);
    while (exp_q.size() > 0 && exp_q[$].cyc > lim) void'(exp_q.pop_back());
  endfunction

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_all_zero(input string name);
    logic [31:0] v;
    v = 32'({bus_if.coo_addr, bus_if.coo_rd_en, bus_if.fm_wm_rd_row, bus_if.mac_clear,
             bus_if.mac_en, bus_if.wr_en, bus_if.wr_row, bus_if.argmax_start,
             bus_if.busy, bus_if.done});
    checks++;
    if (v != 32'd0) begin
      errors++;
      $display("FAIL %s: outputs packed=0x%0h required 0x0", name, v);
    end
  endtask

  // One full pass; argmax_done returned in cycle (argmax+1+w), optionally
  // with a stale pulse during the argmax_start cycle.
  task automatic run_pass(input bit hold, input bit early, input int w);
    int base, a, d;
    @(posedge clk); #1;
    bus_if.start = 1'b1;
    base = cyc;
    push_pass(base);
    busy_lo = base + 1;
    busy_hi = INF;
    a = base + C + 1 + R * (N + 1);
    if (!hold) begin
      @(posedge clk); #1;
      bus_if.start = 1'b0;
    end
    wait_until(a);
    if (early) bus_if.argmax_done = 1'b1;
    @(posedge clk); #1;
    bus_if.argmax_done = 1'b0;
    wait_until(a + 1 + w);
    bus_if.argmax_done = 1'b1;
    d = a + 2 + w;
    push_ev(d, 4, 0, 0, 1'b0);
    busy_hi = d;
    @(posedge clk); #1;
    bus_if.argmax_done = 1'b0;
    bus_if.start = 1'b0;
    @(posedge clk); #1;
  endtask

  // Pass aborted by reset in cycle 20, with start and argmax_done also high.
  task automatic run_reset_pass();
    int base;
    @(posedge clk); #1;
    bus_if.start = 1'b1;
    base = cyc;
    push_pass(base);
    busy_lo = base + 1;
    busy_hi = INF;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    wait_until(base + 20);
    reset = 1'b1;
    bus_if.start = 1'b1;
    bus_if.argmax_done = 1'b1;
    flush_after(base + 20);
    busy_hi = base + 20;
    @(posedge clk); #1;
    check_all_zero("reset_mid_pass");
    reset = 1'b0;
    bus_if.start = 1'b0;
    bus_if.argmax_done = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_all_zero("reset_no_resume");
  endtask

  // Monitor: one-hot, busy window and scoreboard comparison every cycle.
  always @(negedge clk) begin
    int  n_hot;
    bit  exp_busy;
    ev_t o, e;
    n_hot = int'(bus_if.coo_rd_en) + int'(bus_if.mac_en) + int'(bus_if.wr_en)
          + int'(bus_if.argmax_start);
    checks++;
    onehot_chk: assert (n_hot <= 1) else begin
      errors++;
      $display("FAIL onehot cyc=%0d: %0d strobes high, required at most 1", cyc, n_hot);
    end

    exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
    checks++;
    if (bus_if.busy !== exp_busy) begin
      errors++;
      $display("FAIL busy cyc=%0d: got %0b required %0b", cyc, bus_if.busy, exp_busy);
    end

    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_event: kind %0d idx %0d expected at cyc %0d, not seen", e.kind, e.idx, e.cyc);
    end

    if (bus_if.coo_rd_en || bus_if.mac_en || bus_if.wr_en || bus_if.argmax_start ||
        bus_if.done || bus_if.mac_clear) begin
      o.cyc = cyc; o.idx = 0; o.idx2 = 0; o.clr = bus_if.mac_clear;
      if (bus_if.coo_rd_en) begin
        o.kind = 0; o.idx = int'(bus_if.coo_addr);
      end else if (bus_if.mac_en) begin
        o.kind = 1; o.idx = int'(bus_if.fm_wm_rd_row); o.idx2 = int'(bus_if.wr_row);
      end else if (bus_if.wr_en) begin
        o.kind = 2; o.idx2 = int'(bus_if.wr_row);
      end else if (bus_if.argmax_start) begin
        o.kind = 3; o.idx2 = int'(bus_if.wr_row);
      end else if (bus_if.done) begin
        o.kind = 4;
      end else begin
        o.kind = 5;
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d: kind %0d idx %0d row %0d clr %0b, required none",
                 o.cyc, o.kind, o.idx, o.idx2, o.clr);
      end else begin
        e = exp_q.pop_front();
        if (o.cyc != e.cyc || o.kind != e.kind || o.idx != e.idx || o.idx2 != e.idx2 || o.clr != e.clr) begin
          errors++;
          $display("FAIL event: got cyc %0d kind %0d idx %0d row %0d clr %0b, required cyc %0d kind %0d idx %0d row %0d clr %0b",
                   o.cyc, o.kind, o.idx, o.idx2, o.clr, e.cyc, e.kind, e.idx, e.idx2, e.clr);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus_if.start = 1'b0;
    bus_if.argmax_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    reset = 1'b0;
    repeat (2) @(posedge clk);

    run_pass(1'b0, 1'b0, 0);
    run_pass(1'b1, 1'b0, int'($urandom_range(0, 5)));
    repeat (3) @(posedge clk);
    run_reset_pass();
    run_pass(1'b0, 1'b0, 0);
    run_pass(1'b0, 1'b1, 10);
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(0, 4)) @(posedge clk);
      run_pass(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 12)));
    end

    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected events never seen, required 0", exp_q.size());
    end
    check_all_zero("final_idle");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
